// File: rtl/mem_initiator_if.sv
// Bundle of host-command, memory-request and response signals for mem_initiator.
// The master modport is the initiator's view; slave is the host/memory side.
interface mem_initiator_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_wr_rd_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic                  wr_rd_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] rdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_wr_rd_o;
    logic [ADDR_WIDTH-1:0] rsp_addr_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  busy_o;
    logic [7:0]            err_cnt_o;

    modport master (
        input  cmd_valid_i, cmd_wr_rd_i, cmd_addr_i, cmd_wdata_i,
        input  ready_i, rdata_i, rsp_ready_i,
        output cmd_ready_o, addr_o, wdata_o, wr_rd_o, valid_o,
        output rsp_valid_o, rsp_wr_rd_o, rsp_addr_o, rsp_rdata_o, rsp_err_o,
        output busy_o, err_cnt_o
    );

    modport slave (
        output cmd_valid_i, cmd_wr_rd_i, cmd_addr_i, cmd_wdata_i,
        output ready_i, rdata_i, rsp_ready_i,
        input  cmd_ready_o, addr_o, wdata_o, wr_rd_o, valid_o,
        input  rsp_valid_o, rsp_wr_rd_o, rsp_addr_o, rsp_rdata_o, rsp_err_o,
        input  busy_o, err_cnt_o
    );
endinterface

// File: rtl/mem_initiator.sv
// Memory bus master: queues host commands, issues them one at a time over
// valid/ready, and returns one response per command with a timeout error flag.
module mem_initiator #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_initiator_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    logic [CMD_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_wr_rd_q, rsp_wr_rd_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  full, empty, push, pop;
    logic [CMD_W-1:0]      head;

    assign full            = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty           = (count_q == '0);
    assign bus.cmd_ready_o = !full && !rst_i;
    assign push            = bus.cmd_valid_i && bus.cmd_ready_o;
    assign head            = fifo_mem[rd_ptr_q];

    // Storage has no reset; occupancy is tracked solely by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.cmd_wr_rd_i, bus.cmd_addr_i, bus.cmd_wdata_i};
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        valid_d     = valid_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_rd_d = rsp_wr_rd_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    wr_rd_d = head[CMD_W-1];
                    addr_d  = head[DATA_WIDTH +: ADDR_WIDTH];
                    wdata_d = head[CMD_W-1] ? head[DATA_WIDTH-1:0] : '0;
                    valid_d = 1'b1;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A handshake on the final wait cycle takes priority over the timeout.
                if (bus.ready_i) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_wr_rd_d = wr_rd_q;
                    rsp_addr_d  = addr_q;
                    rsp_rdata_d = wr_rd_q ? '0 : bus.rdata_i;
                    rsp_err_d   = 1'b0;
                    wait_d      = '0;
                    state_d     = RSP;
                end else if (wait_q == WAIT_LAST) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_wr_rd_d = wr_rd_q;
                    rsp_addr_d  = addr_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    wait_d      = '0;
                    state_d     = RSP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_q      <= '0;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_rd_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_rd_q <= rsp_wr_rd_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.wr_rd_o     = wr_rd_q;
    assign bus.addr_o      = addr_q;
    assign bus.wdata_o     = wdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_wr_rd_o = rsp_wr_rd_q;
    assign bus.rsp_addr_o  = rsp_addr_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.err_cnt_o   = err_cnt_q;
    assign bus.busy_o      = (state_q != IDLE) || !empty;
endmodule
